// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-requester bus read arbiter.
// Optional feature macro used by this slice: ARB_ROUND_ROBIN_EN.
package bus_arbiter_pkg;

    // Width of both the address and the data paths.
    localparam int BUS_W = 32;

    // Width of the REQ-state wait counter (enough for timeouts up to 255).
    localparam int CNT_W = 8;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Requester identifier: 0 = fetch port (m0), 1 = data port (m1).
    typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-input grant selector producing a one-hot grant.
// ARB_ROUND_ROBIN_EN defined   : a tie goes to the requester not granted last;
//                                the pointer advances on every grant taken.
// ARB_ROUND_ROBIN_EN undefined : fixed priority, m0 wins a tie, no state.
module rr_arbiter
    import bus_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       clock,
    input  logic       reset,
    input  logic       advance,
`endif
    input  logic [1:0] req,
    output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
    // Id of the requester granted most recently; resets to m1 so m0 is favoured first.
    req_id_t last_q;

    // Remember who was granted whenever the owner actually takes a grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant[1];
        end
    end

    // Tie goes to whoever did not win last; a lone request is granted directly.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end
`else
    // Fixed priority: m0 beats m1.
    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0];
        grant[1] = req[1] & ~req[0];
    end
`endif

endmodule

// File: rtl/bus_read_arbiter.sv
// Arbitrates two read requesters (m0 fetch, m1 data) onto one memory read bus.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break instead of
// fixed m0 priority).
//
// Handshakes: a requester raises mN_read_vaild with a stable address and holds
// both until it sees mN_read_ready, a one-cycle pulse with mN_read_data and
// mN_read_error valid in that same cycle. Toward memory, bus_read_vaild and
// bus_read_address stay constant for the whole REQ state; bus_read_ready
// completes the access in the cycle it is sampled high and is ignored outside
// REQ. A requester that drops vaild mid-transaction still gets its pulse.
module bus_read_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             m0_read_vaild,
    input  logic [BUS_W-1:0] m0_read_address,
    output logic             m0_read_ready,
    output logic [BUS_W-1:0] m0_read_data,
    output logic             m0_read_error,
    input  logic             m1_read_vaild,
    input  logic [BUS_W-1:0] m1_read_address,
    output logic             m1_read_ready,
    output logic [BUS_W-1:0] m1_read_data,
    output logic             m1_read_error,
    output logic             bus_read_vaild,
    input  logic             bus_read_ready,
    output logic [BUS_W-1:0] bus_read_address,
    input  logic [BUS_W-1:0] bus_read_data,
    output logic             busy,
    output state_t           dbg_state
);

    // Counter value seen in the last permitted REQ cycle: with the counter
    // cleared on entry, REQ lasts exactly TIMEOUT_CYCLES cycles on a timeout.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [BUS_W-1:0]  addr_q;
    req_id_t           id_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BUS_W-1:0]  data_q;
    logic              err_q;
    logic [1:0]        req_vec;
    logic [1:0]        grant;
    logic              take_grant;
    logic              timeout_hit;

    assign req_vec     = {m1_read_vaild, m0_read_vaild};
    assign take_grant  = (state_q == IDLE) && (req_vec != 2'b00);
    assign timeout_hit = (cnt_q >= TIMEOUT_LAST);

    rr_arbiter u_rr_arbiter (
`ifdef ARB_ROUND_ROBIN_EN
        .clock   (clock),
        .reset   (reset),
        .advance (take_grant),
`endif
        .req     (req_vec),
        .grant   (grant)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> REQ on a grant, REQ -> RESP on ready or timeout,
    // RESP -> IDLE unconditionally so every transaction re-arbitrates.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take_grant) state_d = REQ;
            REQ:     if (bus_read_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction datapath: latch the grant, count REQ cycles, capture the result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            id_q   <= 1'b0;
            cnt_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (take_grant) begin
                addr_q <= grant[1] ? m1_read_address : m0_read_address;
                id_q   <= grant[1];
                cnt_q  <= '0;
            end else if (state_q == REQ) begin
                // A real completion beats a timeout landing in the same cycle.
                if (bus_read_ready) begin
                    data_q <= bus_read_data;
                    err_q  <= 1'b0;
                end else if (timeout_hit) begin
                    data_q <= '0;
                    err_q  <= 1'b1;
                end
                // Saturate rather than wrap.
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Outputs decoded from state; the non-granted requester sees all zeros.
    always_comb begin
        bus_read_vaild   = (state_q == REQ);
        bus_read_address = (state_q == REQ) ? addr_q : '0;
        busy             = (state_q != IDLE);
        dbg_state        = state_q;
        m0_read_ready    = (state_q == RESP) && (id_q == 1'b0);
        m1_read_ready    = (state_q == RESP) && (id_q == 1'b1);
        m0_read_data     = m0_read_ready ? data_q : '0;
        m1_read_data     = m1_read_ready ? data_q : '0;
        m0_read_error    = m0_read_ready & err_q;
        m1_read_error    = m1_read_ready & err_q;
    end

endmodule

// File: tb/tb_bus_read_arbiter.sv
// Directed bench for bus_read_arbiter (built with TIMEOUT_CYCLES = 4).
// Expectations follow ARB_ROUND_ROBIN_EN when the tie-break matters.
module tb_bus_read_arbiter;
    import bus_arbiter_pkg::*;

    localparam int TO = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             m0_read_vaild = 1'b0;
    logic [BUS_W-1:0] m0_read_address = '0;
    logic             m0_read_ready;
    logic [BUS_W-1:0] m0_read_data;
    logic             m0_read_error;
    logic             m1_read_vaild = 1'b0;
    logic [BUS_W-1:0] m1_read_address = '0;
    logic             m1_read_ready;
    logic [BUS_W-1:0] m1_read_data;
    logic             m1_read_error;
    logic             bus_read_vaild;
    logic             bus_read_ready = 1'b0;
    logic [BUS_W-1:0] bus_read_address;
    logic [BUS_W-1:0] bus_read_data = '0;
    logic             busy;
    state_t           dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int m0_pulses = 0;
    int m1_pulses = 0;

    // Expected responses in order: {id, error, data}.
    logic [33:0] exp_q[$];
    logic [33:0] mon_exp;
    logic [33:0] mon_obs;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bus_read_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock            (clock),
        .reset            (reset),
        .m0_read_vaild    (m0_read_vaild),
        .m0_read_address  (m0_read_address),
        .m0_read_ready    (m0_read_ready),
        .m0_read_data     (m0_read_data),
        .m0_read_error    (m0_read_error),
        .m1_read_vaild    (m1_read_vaild),
        .m1_read_address  (m1_read_address),
        .m1_read_ready    (m1_read_ready),
        .m1_read_data     (m1_read_data),
        .m1_read_error    (m1_read_error),
        .bus_read_vaild   (bus_read_vaild),
        .bus_read_ready   (bus_read_ready),
        .bus_read_address (bus_read_address),
        .bus_read_data    (bus_read_data),
        .busy             (busy),
        .dbg_state        (dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        check("rst_state", dbg_state, IDLE);
        check("rst_busy", busy, 0);
        check("rst_bus", {bus_read_vaild, bus_read_address}, 0);
        check("rst_m0", {m0_read_ready, m0_read_error, m0_read_data}, 0);
        check("rst_m1", {m1_read_ready, m1_read_error, m1_read_data}, 0);
        reset = 1'b1;
    endtask

    // Called in the first REQ cycle: answer in REQ cycle number lat.
    task automatic serve(input int lat, input logic [31:0] d);
        for (int i = 1; i < lat; i++) tick();
        bus_read_ready = 1'b1;
        bus_read_data  = d;
        tick();
        bus_read_ready = 1'b0;
        bus_read_data  = '0;
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clock) begin
        if (m0_read_ready || m1_read_ready) begin
            if (m0_read_ready) m0_pulses++;
            if (m1_read_ready) m1_pulses++;
            check("rsp_one_hot", m0_read_ready & m1_read_ready, 0);
            if (m0_read_ready)
                check("m1_quiet", {m1_read_ready, m1_read_error, m1_read_data}, 0);
            else
                check("m0_quiet", {m0_read_ready, m0_read_error, m0_read_data}, 0);
            mon_obs = m1_read_ready ? {1'b1, m1_read_error, m1_read_data}
                                    : {1'b0, m0_read_error, m0_read_data};
            if (exp_q.size() == 0) begin
                check("rsp_expected", exp_q.size(), 1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp", mon_obs, mon_exp);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int p0;
        int p1;
        logic exp_id;

        apply_reset();

        // Single request from m0, memory answers in the 2nd REQ cycle.
        m0_read_address = 32'h0000_1000;
        m0_read_vaild   = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
        tick();
        check("t1_bus_vaild", bus_read_vaild, 1);
        check("t1_bus_addr", bus_read_address, 32'h0000_1000);
        check("t1_busy", busy, 1);
        serve(2, 32'hDEAD_BEEF);
        check("t1_resp_state", dbg_state, RESP);
        check("t1_bus_vaild_low", bus_read_vaild, 0);
        m0_read_vaild = 1'b0;
        tick();
        check("t1_m0_pulses", m0_pulses, 1);
        check("t1_m1_pulses", m1_pulses, 0);
        check("t1_idle", busy, 0);

        // bus_read_ready outside REQ is ignored.
        bus_read_ready = 1'b1;
        bus_read_data  = 32'h5555_5555;
        tick();
        tick();
        bus_read_ready = 1'b0;
        bus_read_data  = '0;
        check("ign_busy", busy, 0);
        check("ign_pulses", m0_pulses + m1_pulses, 1);

        // Tie: both held valid for 4 transactions from a fresh reset.
        apply_reset();
        m0_read_address = 32'h0000_0100;
        m1_read_address = 32'h0000_0200;
        m0_read_vaild   = 1'b1;
        m1_read_vaild   = 1'b1;
        p0 = m0_pulses;
        p1 = m1_pulses;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_id = (k % 2 == 1);
`else
            exp_id = 1'b0;
`endif
            exp_q.push_back({exp_id, 1'b0, 32'hA000_0000 + 32'(k)});
            tick();
            check("t2_grant_addr", bus_read_address, exp_id ? 32'h0000_0200 : 32'h0000_0100);
            serve(1, 32'hA000_0000 + 32'(k));
            tick();
        end
        m0_read_vaild = 1'b0;
        m1_read_vaild = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        check("t2_m0_count", m0_pulses - p0, 2);
        check("t2_m1_count", m1_pulses - p1, 2);
`else
        check("t2_m0_count", m0_pulses - p0, 4);
        check("t2_m1_count", m1_pulses - p1, 0);
`endif

        // Timeout on m1: memory never answers.
        m1_read_address = 32'h0000_3000;
        m1_read_vaild   = 1'b1;
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        tick();
        n = 0;
        while (bus_read_vaild && n < 50) begin
            n++;
            tick();
        end
        check("t3_vaild_cycles", n, TO);
        check("t3_resp_state", dbg_state, RESP);
        m1_read_vaild = 1'b0;
        tick();

        // Collision: ready arrives in the cycle the timeout would fire.
        m0_read_address = 32'h0000_4000;
        m0_read_vaild   = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
        tick();
        serve(TO, 32'h1234_5678);
        check("t4_resp_state", dbg_state, RESP);
        m0_read_vaild = 1'b0;
        tick();

        // Reset during REQ after an m0 grant; next tie must still go to m0.
        m0_read_address = 32'h0000_5000;
        m0_read_vaild   = 1'b1;
        tick();
        check("t5_in_req", bus_read_vaild, 1);
        #1 reset = 1'b0;
        #1;
        check("t5_vaild_drop", bus_read_vaild, 0);
        check("t5_busy_drop", busy, 0);
        check("t5_state", dbg_state, IDLE);
        p0 = m0_pulses + m1_pulses;
        tick();
        tick();
        tick();
        m1_read_address = 32'h0000_5100;
        m1_read_vaild   = 1'b1;
        reset = 1'b1;
        tick();
        check("t5_no_pulse", m0_pulses + m1_pulses, p0);
        check("t5_regrant_addr", bus_read_address, 32'h0000_5000);
        exp_q.push_back({1'b0, 1'b0, 32'h0000_5A5A});
        serve(1, 32'h0000_5A5A);
        m0_read_vaild = 1'b0;
        m1_read_vaild = 1'b0;
        tick();

        // Withdrawn request: m1 drops vaild one cycle after its grant.
        m1_read_address = 32'h0000_6000;
        m1_read_vaild   = 1'b1;
        p1 = m1_pulses;
        exp_q.push_back({1'b1, 1'b0, 32'h6666_0001});
        tick();
        m1_read_vaild = 1'b0;
        check("t6_bus_addr", bus_read_address, 32'h0000_6000);
        serve(2, 32'h6666_0001);
        tick();
        tick();
        check("t6_m1_pulses", m1_pulses - p1, 1);
        check("t6_idle", busy, 0);

        // ---------------- final report ----------------
        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
